// File: rtl/conv_window_controller.sv
// ---------------------------------------------------------------------------
// conv_window_controller
//
// Sequencing controller for a sliding-window convolution datapath. It counts
// accepted pixels in raster order (col, row) and flags when the datapath
// holds a complete filterWidth x filterWidth window. A flagged window is
// reported one cycle after its bottom-right pixel is accepted, together with
// the window's top-left coordinate.
//
// Ports
//   clock         rising-edge clock
//   reset_n       synchronous active-low reset
//   start         begin a frame (only honoured in IDLE)
//   abort         cancel the current frame (FILL/RUN), overrides isValid
//   isValid       upstream pixel present this cycle
//   in_ready      controller accepts pixels this cycle
//   shift_en      isValid && in_ready: datapath shifts data_in this cycle
//   window_valid  registered: window complete
//   out_col       top-left column of the reported window
//   out_row       top-left row of the reported window
//   window_count  windows emitted in the current frame (wraps at 2^16)
//   busy          FSM is not IDLE
//   frame_done    one-cycle end-of-frame pulse (DONE state)
//   state_dbg     current FSM state encoding, for observation only
//
// Handshake: a pixel transfers in exactly the cycles where isValid and
// in_ready are both high (shift_en). in_ready never depends on isValid.
// ---------------------------------------------------------------------------
module conv_window_controller #(
    parameter int bitwidth    = 8,
    parameter int filterWidth = 3,
    parameter int imageWidth  = 11,
    parameter int imageHeight = 11
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           isValid,
    output logic                           in_ready,
    output logic                           shift_en,
    output logic                           window_valid,
    output logic [$clog2(imageWidth)-1:0]  out_col,
    output logic [$clog2(imageHeight)-1:0] out_row,
    output logic [15:0]                    window_count,
    output logic                           busy,
    output logic                           frame_done,
    output logic [1:0]                     state_dbg
);

    localparam int CW = $clog2(imageWidth);
    localparam int RW = $clog2(imageHeight);

    localparam logic [CW-1:0] COL_FIRST = CW'(filterWidth - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(imageWidth - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(filterWidth - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(imageHeight - 1);

    // Elaboration-time parameter sanity checks.
    if (filterWidth > imageWidth || filterWidth > imageHeight) begin : g_bad_filter
        $error("conv_window_controller: filterWidth exceeds image dimensions");
    end
    if (bitwidth < 1) begin : g_bad_bitwidth
        $error("conv_window_controller: bitwidth must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            accepting;
    logic            win_pixel;
    logic            last_pixel;

    // Kept separate from the FSM block so shift_en never feeds back into
    // the process that produces in_ready.
    assign accepting  = (state == FILL || state == RUN) && !abort;
    assign in_ready   = accepting;
    assign shift_en   = isValid && accepting;

    // The current (col,row) is the position of the pixel being offered.
    assign win_pixel  = (col >= COL_FIRST) && (row >= ROW_FIRST);
    assign last_pixel = (col == COL_LAST) && (row == ROW_LAST);

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    assign state_dbg  = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = FILL;
            FILL: begin
                if (abort)
                    state_next = IDLE;
                // A filter as large as the image makes the first window
                // pixel also the last pixel of the frame.
                else if (shift_en && win_pixel)
                    state_next = last_pixel ? DONE : RUN;
            end
            RUN: begin
                if (abort)
                    state_next = IDLE;
                else if (shift_en && last_pixel)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            window_count <= '0;
            out_col      <= '0;
            out_row      <= '0;
            window_valid <= 1'b0;
        end else begin
            state        <= state_next;
            window_valid <= shift_en && win_pixel;
            if (state == IDLE && start) begin
                col          <= '0;
                row          <= '0;
                window_count <= '0;
            end else if (shift_en) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    // Return to the origin after the final pixel so the
                    // row counter never leaves the image.
                    row <= last_pixel ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (win_pixel) begin
                    out_col      <= col - COL_FIRST;
                    out_row      <= row - ROW_FIRST;
                    window_count <= window_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_controller.sv
// ---------------------------------------------------------------------------
// tb_conv_window_controller
//
// Drives frames with randomized pixel gaps, stray start pulses, aborts and a
// mid-frame reset. A reference model tracks the frame as a count of accepted
// pixels and derives each pixel's (row,col) and window status arithmetically.
// Predicted windows go into an expected queue and are matched against the
// DUT's window_valid reports.
// ---------------------------------------------------------------------------
module tb_conv_window_controller;

  localparam int BW = 8;
  localparam int FW = 3;
  localparam int IW = 11;
  localparam int IH = 11;
  localparam int CW = $clog2(IW);
  localparam int RW = $clog2(IH);
  localparam int WINDOWS = (IW - FW + 1) * (IH - FW + 1);

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          isValid = 1'b0;
  logic          in_ready, shift_en, window_valid, busy, frame_done;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic [15:0]   window_count;
  logic [1:0]    state_dbg;

  always #5 clock = ~clock;

  conv_window_controller #(
    .bitwidth(BW), .filterWidth(FW), .imageWidth(IW), .imageHeight(IH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .isValid(isValid), .in_ready(in_ready), .shift_en(shift_en),
    .window_valid(window_valid), .out_col(out_col), .out_row(out_row),
    .window_count(window_count), .busy(busy), .frame_done(frame_done),
    .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_known = 0;   // model valid once the first reset edge passes
  bit          m_active = 0;  // frame in progress, pixels may be accepted
  bit          m_done = 0;    // end-of-frame cycle
  int          pix = 0;       // pixels accepted in current frame
  int          wc = 0;
  bit          wv = 0;
  int          orow = 0, ocol = 0;
  logic [15:0] exp_q[$];      // {row, col} of predicted windows

  // per-frame observations
  int cyc = 0, frame_start = 0, first_wv = -1;
  int windows_seen = 0, done_pulses = 0, last_r = -1, last_c = -1;

  // ---------------- driver ----------------
  task automatic step(input bit rst_n_i, input bit start_i, input bit abort_i, input bit valid_i);
    bit   exp_ir;
    int   r, c;
    logic [15:0] e;
    @(negedge clock);
    reset_n = rst_n_i;
    start   = start_i;
    abort   = abort_i;
    isValid = valid_i;
    #1;
    if (m_known) begin
      exp_ir = m_active && !abort_i;
      check("in_ready", in_ready, exp_ir);
      check("shift_en", shift_en, exp_ir && valid_i);
    end
    // model update for this edge
    if (!rst_n_i) begin
      m_active = 0; m_done = 0; pix = 0; wc = 0; wv = 0; orow = 0; ocol = 0;
      exp_q.delete();
      m_known = 1;
    end else if (m_done) begin
      m_done = 0; wv = 0;
    end else if (!m_active) begin
      wv = 0;
      if (start_i) begin m_active = 1; pix = 0; wc = 0; end
    end else if (abort_i) begin
      m_active = 0; wv = 0;
    end else if (valid_i) begin
      r = pix / IW;
      c = pix % IW;
      wv = (r >= FW - 1) && (c >= FW - 1);
      if (wv) begin
        orow = r - (FW - 1);
        ocol = c - (FW - 1);
        wc = (wc + 1) % 65536;
        exp_q.push_back({8'(orow), 8'(ocol)});
      end
      pix++;
      if (pix == IW * IH) begin m_active = 0; m_done = 1; end
    end else begin
      wv = 0;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (m_known) begin
      check("window_valid", window_valid, wv);
      check("window_count", window_count, wc);
      check("out_row", out_row, orow);
      check("out_col", out_col, ocol);
      check("busy", busy, m_active || m_done);
      check("frame_done", frame_done, m_done);
      if (frame_done === 1'b1) done_pulses++;
      if (window_valid === 1'b1) begin
        windows_seen++;
        if (first_wv < 0) first_wv = cyc - frame_start;
        last_r = out_row;
        last_c = out_col;
        if (exp_q.size() == 0) begin
          check("spurious_window", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_row", out_row, e[15:8]);
          check("sb_col", out_col, e[7:0]);
        end
      end
    end
  endtask

  task automatic clear_obs();
    first_wv = -1; windows_seen = 0; done_pulses = 0; last_r = -1; last_c = -1;
  endtask

  // Runs one frame from IDLE. pct: isValid probability (%); abort_at: abort
  // when that many pixels are accepted (-1 none); gap_at: one forced
  // isValid=0 cycle after that many pixels (-1 none).
  task automatic run_frame(input int pct, input int abort_at, input int gap_at);
    bit gap_used = 0;
    bit v, ab, st;
    int n;
    clear_obs();
    step(1, 1, 0, 0);
    frame_start = cyc;
    for (n = 0; n < 3000; n++) begin
      v  = ($urandom_range(99, 0) < pct);
      if (gap_at >= 0 && pix == gap_at && !gap_used) begin v = 0; gap_used = 1; end
      ab = (abort_at >= 0 && pix == abort_at);
      st = ($urandom_range(9, 0) == 0);   // stray start while busy
      step(1, st, ab, v);
      if (!m_active && !m_done) break;
    end
    if (n >= 3000) check("frame_timeout", 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    check("rst_busy", busy, 0);
    check("rst_window_count", window_count, 0);

    // continuous frame
    run_frame(100, -1, -1);
    check("cont_first_wv", first_wv, 25);
    check("cont_windows", windows_seen, WINDOWS);
    check("cont_last_row", last_r, IH - FW);
    check("cont_last_col", last_c, IW - FW);
    check("cont_done_pulses", done_pulses, 1);
    check("cont_count", window_count, WINDOWS);
    check("cont_q_empty", exp_q.size(), 0);

    // single gap after pixel 19
    run_frame(100, -1, 19);
    check("gap_first_wv", first_wv, 26);
    check("gap_windows", windows_seen, WINDOWS);
    check("gap_last_row", last_r, IH - FW);
    check("gap_last_col", last_c, IW - FW);
    check("gap_done_pulses", done_pulses, 1);

    // abort after 40 pixels, then a fresh frame
    run_frame(100, 40, -1);
    check("abort_done_pulses", done_pulses, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    run_frame(70, -1, -1);
    check("post_abort_windows", windows_seen, WINDOWS);
    check("post_abort_count", window_count, WINDOWS);

    // randomized frames
    for (int f = 0; f < 3; f++) begin
      run_frame($urandom_range(100, 40), -1, -1);
      check("rand_windows", windows_seen, WINDOWS);
      check("rand_done_pulses", done_pulses, 1);
    end

    // reset during RUN
    clear_obs();
    step(1, 1, 0, 0);
    for (int i = 0; i < 60; i++) step(1, i % 7 == 0, 0, 1);
    check("pre_rst_busy", busy, 1);
    step(0, 1, 1, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wv", window_valid, 0);
    check("mid_rst_count", window_count, 0);
    check("mid_rst_row", out_row, 0);
    check("mid_rst_col", out_col, 0);
    step(1, 0, 0, 1);
    run_frame(85, -1, -1);
    check("post_rst_windows", windows_seen, WINDOWS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
